// File: rtl/axis_to_dvs_frame_v1.sv
// axis_to_dvs_frame_v1
// AXI4-Stream video slave: unpacks {alpha, 6'b0, ref[9:0], pix[7:0]} beats
// into DVS frame-buffer write cycles with a linear raster address.
// Configuration macro: AXIS_TO_DVS_FRAME_CHECK_EN enables tlast/tuser
// framing checks and the sync_error pulse. Without it, tlast is ignored and
// sync_error stays 0.
module axis_to_dvs_frame_v1 #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic        mem_ready,
  output logic [7:0]  pix_out,
  output logic [9:0]  ref_out,
  output logic [16:0] address,
  output logic        write_enable,
  output logic        frame_done,
  output logic        sync_error
);

`ifdef AXIS_TO_DVS_FRAME_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [0:0] WAIT_SOF = 1'b0;
  localparam logic [0:0] ACTIVE   = 1'b1;

  logic [0:0]  state;
  logic [8:0]  col;
  logic [7:0]  row;
  logic [16:0] row_base;

  logic in_active;
  logic accept;
  logic last_col;
  logic last_row;
  logic line_end;
  logic framing_err;
  logic unused_ok;

  // Handshake and raster decode; SOF beats always wait for the frame buffer
  always_comb begin
    in_active   = (state == ACTIVE);
    s_axis_tready = reset & ((in_active | s_axis_tuser) ? mem_ready : 1'b1);
    accept      = s_axis_tvalid & s_axis_tready;
    last_col    = (col == 9'(H_ACTIVE - 1));
    last_row    = (row == 8'(V_ACTIVE - 1));
    line_end    = last_col | (CHECK_EN & s_axis_tlast);
    framing_err = CHECK_EN & (s_axis_tlast ^ last_col);
    unused_ok   = ^s_axis_tdata[31:18];
  end

  // Raster counters, state and registered write cycle
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state        <= WAIT_SOF;
      col          <= '0;
      row          <= '0;
      row_base     <= '0;
      pix_out      <= '0;
      ref_out      <= '0;
      address      <= '0;
      write_enable <= 1'b0;
      frame_done   <= 1'b0;
      sync_error   <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      frame_done   <= 1'b0;
      sync_error   <= 1'b0;
      if (accept) begin
        if (s_axis_tuser) begin
          write_enable <= 1'b1;
          address      <= '0;
          pix_out      <= s_axis_tdata[7:0];
          ref_out      <= s_axis_tdata[17:8];
          col          <= 9'd1;
          row          <= '0;
          row_base     <= '0;
          state        <= ACTIVE;
          sync_error   <= CHECK_EN & in_active;
        end else if (in_active) begin
          write_enable <= 1'b1;
          address      <= row_base + {8'b0, col};
          pix_out      <= s_axis_tdata[7:0];
          ref_out      <= s_axis_tdata[17:8];
          sync_error   <= framing_err;
          if (line_end) begin
            col      <= '0;
            row      <= row + 8'd1;
            row_base <= row_base + 17'(H_ACTIVE);
            if (last_row) begin
              frame_done <= 1'b1;
              state      <= WAIT_SOF;
            end
          end else begin
            col <= col + 9'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_to_dvs_frame_v1.sv
// Testbench for axis_to_dvs_frame_v1: directed stream vectors, a raster-level
// reference model checked every cycle, and literal spot values.
module tb_axis_to_dvs_frame_v1;
  localparam int H = 320;
  localparam int V = 12;
`ifdef AXIS_TO_DVS_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        pclk;
  logic        reset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic        mem_ready;
  logic [7:0]  pix_out;
  logic [9:0]  ref_out;
  logic [16:0] address;
  logic        write_enable;
  logic        frame_done;
  logic        sync_error;

  axis_to_dvs_frame_v1 #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .pclk(pclk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .mem_ready(mem_ready),
    .pix_out(pix_out), .ref_out(ref_out), .address(address),
    .write_enable(write_enable), .frame_done(frame_done),
    .sync_error(sync_error)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  // reference model state: where the next pixel lands in the raster
  bit m_active = 1'b0;
  int m_row = 0;
  int m_col = 0;
  bit exp_we = 1'b0;
  int exp_addr = 0;
  logic [7:0] exp_pix = '0;
  logic [9:0] exp_ref = '0;
  bit exp_fd = 1'b0;
  bit exp_se = 1'b0;
  bit exp_rdy;
  bit m_acc;
  bit m_lastc;
  bit m_eol;

  int wr_count = 0;
  int fd_count = 0;
  int last_addr = -1;
  int fd_addr = -1;

  // Compare DUT against the model at every falling edge, then advance the model
  always @(negedge pclk) begin
    if (!reset) begin
      checks++;
      if ({write_enable, frame_done, sync_error, pix_out, ref_out, address, s_axis_tready} !== '0) begin
        errors++;
        $display("FAIL reset_state we=%0b fd=%0b se=%0b pix=%0h ref=%0h addr=%0d rdy=%0b required all 0",
                 write_enable, frame_done, sync_error, pix_out, ref_out, address, s_axis_tready);
      end
      m_active = 1'b0;
      exp_we = 1'b0; exp_fd = 1'b0; exp_se = 1'b0;
    end else begin
      if (write_enable === 1'b1) begin
        wr_count++;
        last_addr = int'(address);
        if (frame_done === 1'b1) begin
          fd_count++;
          fd_addr = int'(address);
        end
      end
      checks++;
      if (exp_we) begin
        if (write_enable !== 1'b1 || address !== 17'(exp_addr) || pix_out !== exp_pix ||
            ref_out !== exp_ref || frame_done !== exp_fd || sync_error !== exp_se) begin
          errors++;
          $display("FAIL write we=%0b addr=%0d pix=%0h ref=%0h fd=%0b se=%0b required we=1 addr=%0d pix=%0h ref=%0h fd=%0b se=%0b",
                   write_enable, address, pix_out, ref_out, frame_done, sync_error,
                   exp_addr, exp_pix, exp_ref, exp_fd, exp_se);
        end
      end else if (write_enable !== 1'b0 || frame_done !== 1'b0 || sync_error !== 1'b0) begin
        errors++;
        $display("FAIL idle we=%0b fd=%0b se=%0b addr=%0d required we=0 fd=0 se=0",
                 write_enable, frame_done, sync_error, address);
      end
      exp_rdy = (m_active || s_axis_tuser) ? mem_ready : 1'b1;
      checks++;
      if (s_axis_tready !== exp_rdy) begin
        errors++;
        $display("FAIL tready actual=%0b required=%0b", s_axis_tready, exp_rdy);
      end
      m_acc = s_axis_tvalid && exp_rdy;
      exp_we = 1'b0; exp_fd = 1'b0; exp_se = 1'b0;
      if (m_acc) begin
        if (s_axis_tuser) begin
          exp_we = 1'b1;
          exp_addr = 0;
          exp_se = CHK && m_active;
          m_active = 1'b1;
          m_row = 0;
          m_col = 1;
        end else if (m_active) begin
          m_lastc = (m_col == H - 1);
          m_eol = m_lastc || (CHK && s_axis_tlast);
          exp_we = 1'b1;
          exp_addr = m_row * H + m_col;
          exp_se = CHK && (s_axis_tlast != m_lastc);
          if (m_eol) begin
            m_col = 0;
            if (m_row == V - 1) begin
              exp_fd = 1'b1;
              m_active = 1'b0;
            end
            m_row++;
          end else begin
            m_col++;
          end
        end
        exp_pix = s_axis_tdata[7:0];
        exp_ref = s_axis_tdata[17:8];
      end
    end
  end

  int cyc = 0;
  bit toggle = 1'b0;
  int seq = 0;
  int tb_col = 0;
  int w0 = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    cyc++;
    if (toggle) mem_ready = ((cyc / 3) % 2) == 0;
  endtask

  function automatic logic [31:0] pat(input int i);
    return {14'h2A5A ^ 14'(i), 10'(i * 7 + 3), 8'(i * 13 + 1)};
  endfunction

  task automatic send(input logic [31:0] d, input bit u, input bit l);
    bit acc;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge pclk);
      acc = s_axis_tready;
      step();
    end
    if (!acc) begin
      errors++; checks++;
      $display("FAIL handshake_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      send(pat(seq), 1'b0, tb_col == H - 1);
      seq++;
      tb_col = (tb_col == H - 1) ? 0 : tb_col + 1;
    end
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    step();
    step();
  endtask

  initial begin
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
    s_axis_tlast = 1'b0; mem_ready = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
    step(); step(); step();
    chk("tready_in_reset", int'(s_axis_tready), 0);
    chk("we_in_reset", int'(write_enable), 0);
    reset = 1'b1;
    step();

    // non-SOF beats before the first frame are discarded
    for (int i = 0; i < 5; i++) send(32'h0000_0155, 1'b0, 1'b0);
    idle();
    chk("presof_writes", wr_count, 0);
    send(32'hFF00_03AB, 1'b1, 1'b0);
    chk("sof_pix", int'(pix_out), 'hAB);
    chk("sof_ref", int'(ref_out), 'h003);
    chk("sof_addr", int'(address), 0);
    chk("sof_we", int'(write_enable), 1);
    tb_col = 1;
    run(H * V - 1);
    idle();
    chk("frame_writes", wr_count, H * V);
    chk("frame_done_count", fd_count, 1);
    chk("frame_done_addr", fd_addr, H * V - 1);
    chk("frame_last_addr", last_addr, H * V - 1);
    send(pat(1), 1'b0, 1'b1);
    idle();
    chk("post_frame_discard", wr_count, H * V);

    // mem_ready toggling every 3 cycles
    w0 = wr_count;
    toggle = 1'b1;
    send(pat(seq), 1'b1, 1'b0); seq++;
    tb_col = 1;
    run(699);
    toggle = 1'b0; mem_ready = 1'b1;
    idle();
    chk("stall_writes", wr_count - w0, 700);
    chk("stall_last_addr", last_addr, 699);

    // early tlast at column 100 of row 0
    send(pat(seq), 1'b1, 1'b0); seq++;
    tb_col = 1;
    run(99);
    send(pat(seq), 1'b0, 1'b1); seq++;
    chk("early_tlast_addr", int'(address), 100);
    chk("early_tlast_err", int'(sync_error), int'(CHK));
    send(pat(seq), 1'b0, 1'b0); seq++;
    chk("after_early_addr", int'(address), CHK ? 320 : 101);
    chk("after_early_err", int'(sync_error), 0);

    // tuser in the middle of a frame at row 5 col 7
    send(pat(seq), 1'b1, 1'b0); seq++;
    tb_col = 1;
    run(5 * H + 7 - 1);
    idle();
    chk("pre_restart_addr", last_addr, 5 * H + 6);
    send(pat(seq), 1'b1, 1'b0); seq++;
    chk("restart_addr", int'(address), 0);
    chk("restart_err", int'(sync_error), int'(CHK));
    send(pat(seq), 1'b0, 1'b0); seq++;
    chk("restart_next_addr", int'(address), 1);
    tb_col = 2;

    // reset for 2 cycles at row 10
    run(10 * H - 2 + 5);
    s_axis_tvalid = 1'b1;
    reset = 1'b0;
    #1;
    chk("midreset_addr", int'(address), 0);
    chk("midreset_we", int'(write_enable), 0);
    chk("midreset_tready", int'(s_axis_tready), 0);
    step(); step();
    s_axis_tvalid = 1'b0;
    reset = 1'b1;
    step();
    w0 = wr_count;
    for (int i = 0; i < 5; i++) begin send(pat(seq), 1'b0, 1'b0); seq++; end
    idle();
    chk("postreset_discard", wr_count - w0, 0);
    send(pat(seq), 1'b1, 1'b0); seq++;
    chk("postreset_sof_addr", int'(address), 0);

    // missing tlast at the last column
    for (int c = 1; c < H; c++) begin send(pat(seq), 1'b0, 1'b0); seq++; end
    chk("missing_tlast_addr", int'(address), H - 1);
    chk("missing_tlast_err", int'(sync_error), int'(CHK));
    send(pat(seq), 1'b0, 1'b0); seq++;
    chk("missing_next_addr", int'(address), H);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
